// File: rtl/eeprom_test_pkg.sv
// rtl/eeprom_test_pkg.sv - shared types and constants for the EEPROM read/write self-test
package eeprom_test_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        WR_GAP  = 3'd3,
        RD_REQ  = 3'd4,
        RD_WAIT = 3'd5,
        PASS    = 3'd6,
        FAIL    = 3'd7
    } state_t;

    localparam logic I2C_WR   = 1'b0;
    localparam logic I2C_RD   = 1'b1;
    localparam logic I2C_NACK = 1'b1;

    // Largest of the three wait lengths; sizes the shared delay counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/delay_cnt.sv
// rtl/delay_cnt.sv - loadable down-counter with zero flag, shared by all waits
module delay_cnt #(
    parameter int unsigned    W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/eeprom_rw_test.sv
// rtl/eeprom_rw_test.sv - EEPROM write-then-readback self-test sequencer
module eeprom_rw_test
    import eeprom_test_pkg::*;
#(
    parameter int unsigned START_DLY   = 25_000,
    parameter int unsigned WR_BYTES    = 16,
    parameter logic [15:0] START_ADDR  = 16'h0000,
    parameter int unsigned WAIT_CYCLES = 250_000,
    parameter int unsigned TIMEOUT     = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        i2c_exec,
    output logic        i2c_rh_wl,
    output logic [15:0] i2c_addr,
    output logic [7:0]  i2c_data_w,
    input  logic [7:0]  i2c_data_r,
    input  logic        i2c_done,
    input  logic        i2c_ack,
    output logic        rw_done,
    output logic        rw_result,
    output logic [15:0] fail_addr
);

    localparam int unsigned    CNT_MAX  = max3(START_DLY, WAIT_CYCLES, TIMEOUT);
    localparam int unsigned    CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(START_DLY - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]       LAST_IDX = 8'(WR_BYTES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_idx;
    logic [7:0]         w_idx_next;
    logic [15:0]        r_addr;
    logic [7:0]         r_data_w;
    logic               r_rh_wl;
    logic [15:0]        r_fail_addr;
    logic               w_cnt_load;
    logic [CNT_W-1:0]   w_cnt_val;
    logic               w_cnt_en;
    logic               w_cnt_zero;
    logic               w_nack;

    assign w_nack = (i2c_ack == I2C_NACK);

    // The reset value doubles as the power-up settle delay for IDLE.
    delay_cnt #(
        .W       (CNT_W),
        .RST_VAL (DLY_LOAD)
    ) u_delay_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_en       (w_cnt_en),
        .o_zero     (w_cnt_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and next byte index; i2c_done beats the timeout when both occur.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            IDLE: begin
                if (w_cnt_zero) begin
                    w_state_next = WR_REQ;
                end
            end
            WR_REQ: w_state_next = WR_WAIT;
            WR_WAIT: begin
                if (i2c_done) begin
                    w_state_next = w_nack ? FAIL : WR_GAP;
                end else if (w_cnt_zero) begin
                    w_state_next = FAIL;
                end
            end
            WR_GAP: begin
                if (w_cnt_zero) begin
                    if (r_idx == LAST_IDX) begin
                        w_idx_next   = 8'd0;
                        w_state_next = RD_REQ;
                    end else begin
                        w_idx_next   = r_idx + 8'd1;
                        w_state_next = WR_REQ;
                    end
                end
            end
            RD_REQ: w_state_next = RD_WAIT;
            RD_WAIT: begin
                if (i2c_done) begin
                    if (w_nack || (i2c_data_r != r_idx)) begin
                        w_state_next = FAIL;
                    end else if (r_idx == LAST_IDX) begin
                        w_state_next = PASS;
                    end else begin
                        w_idx_next   = r_idx + 8'd1;
                        w_state_next = RD_REQ;
                    end
                end else if (w_cnt_zero) begin
                    w_state_next = FAIL;
                end
            end
            PASS: w_state_next = PASS;
            FAIL: w_state_next = FAIL;
            default: w_state_next = IDLE;
        endcase
    end

    // Arm the timeout on each request and the write-cycle pause after each good write.
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_val  = TMO_LOAD;
        w_cnt_en   = (r_state != PASS) && (r_state != FAIL);
        if ((r_state == WR_REQ) || (r_state == RD_REQ)) begin
            w_cnt_load = 1'b1;
            w_cnt_val  = TMO_LOAD;
        end else if ((r_state == WR_WAIT) && (w_state_next == WR_GAP)) begin
            w_cnt_load = 1'b1;
            w_cnt_val  = GAP_LOAD;
        end
    end

    // Transfer fields are latched on entry to a request so they hold until done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx       <= 8'd0;
            r_addr      <= 16'h0000;
            r_data_w    <= 8'h00;
            r_rh_wl     <= I2C_WR;
            r_fail_addr <= 16'h0000;
        end else begin
            r_idx <= w_idx_next;
            if ((w_state_next == WR_REQ) || (w_state_next == RD_REQ)) begin
                r_addr   <= START_ADDR + {8'h00, w_idx_next};
                r_data_w <= w_idx_next;
                r_rh_wl  <= (w_state_next == RD_REQ) ? I2C_RD : I2C_WR;
            end
            if ((w_state_next == FAIL) && (r_state != FAIL)) begin
                r_fail_addr <= r_addr;
            end
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        i2c_exec  = 1'b0;
        rw_done   = 1'b0;
        rw_result = 1'b0;
        case (r_state)
            WR_REQ, RD_REQ: i2c_exec = 1'b1;
            PASS: begin
                rw_done   = 1'b1;
                rw_result = 1'b1;
            end
            FAIL: rw_done = 1'b1;
            default: ;
        endcase
    end

    assign i2c_rh_wl  = r_rh_wl;
    assign i2c_addr   = r_addr;
    assign i2c_data_w = r_data_w;
    assign fail_addr  = r_fail_addr;

endmodule

// File: tb/tb_eeprom_rw_test.sv
// tb/tb_eeprom_rw_test.sv - self-checking bench for eeprom_rw_test
module tb_eeprom_rw_test;

    localparam int          P_START_DLY = 5;
    localparam int          P_WR_BYTES  = 4;
    localparam int          P_WAIT      = 10;
    localparam int          P_TIMEOUT   = 100;
    localparam logic [15:0] P_ADDR      = 16'h0010;

    localparam int K_NONE = 0, K_NACK_WR = 1, K_NACK_RD = 2, K_BAD_RD = 3, K_DROP_WR = 4;

    typedef struct {
        logic        rh;
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i2c_exec, i2c_rh_wl, rw_done, rw_result;
    logic [15:0] i2c_addr, fail_addr;
    logic [7:0]  i2c_data_w;
    logic        slv_done = 1'b0, slv_ack = 1'b0, tb_done = 1'b0, tb_ack = 1'b0;
    logic [7:0]  slv_rdata = 8'h00;
    wire         i2c_done = slv_done | tb_done;
    wire         i2c_ack  = slv_ack | tb_ack;

    int          cyc = 0;
    int          n_cmp = 0, n_fail = 0;
    txn_t        log_q[$];
    txn_t        exp_q[$];
    logic        exp_res;
    logic [15:0] exp_fa;
    int          fault_kind = K_NONE;
    logic [15:0] fault_addr = 16'h0;
    logic        drop_rd = 1'b0;
    int          slv_lat = 20;
    int          done_set_cyc = 0, done_cnt = 0, hold_err = 0, rd_cnt = 0;
    int          rel_cyc = 0;
    logic [7:0]  mem [256];

    eeprom_rw_test #(
        .START_DLY   (P_START_DLY),
        .WR_BYTES    (P_WR_BYTES),
        .START_ADDR  (P_ADDR),
        .WAIT_CYCLES (P_WAIT),
        .TIMEOUT     (P_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i2c_exec   (i2c_exec),
        .i2c_rh_wl  (i2c_rh_wl),
        .i2c_addr   (i2c_addr),
        .i2c_data_w (i2c_data_w),
        .i2c_data_r (slv_rdata),
        .i2c_done   (i2c_done),
        .i2c_ack    (i2c_ack),
        .rw_done    (rw_done),
        .rw_result  (rw_result),
        .fail_addr  (fail_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected transfers and verdict, straight from the test-pattern rules.
    task automatic build_model(input int kind, input logic [15:0] faddr);
        txn_t t;
        exp_q.delete();
        exp_res = 1'b1;
        exp_fa  = 16'h0000;
        for (int i = 0; i < P_WR_BYTES; i++) begin
            t.rh = 1'b0; t.addr = P_ADDR + 16'(i); t.data = 8'(i); t.cyc = 0;
            exp_q.push_back(t);
            if ((kind == K_NACK_WR || kind == K_DROP_WR) && t.addr == faddr) begin
                exp_res = 1'b0; exp_fa = t.addr; return;
            end
        end
        for (int i = 0; i < P_WR_BYTES; i++) begin
            t.rh = 1'b1; t.addr = P_ADDR + 16'(i); t.data = 8'(i); t.cyc = 0;
            exp_q.push_back(t);
            if ((kind == K_NACK_RD || kind == K_BAD_RD) && t.addr == faddr) begin
                exp_res = 1'b0; exp_fa = t.addr; return;
            end
        end
    endtask

    // Slave: logs each request, checks fields hold, answers after slv_lat cycles.
    initial begin : slave
        txn_t       t;
        logic       drop, nack;
        logic [7:0] rd;
        step();
        forever begin
            if (i2c_exec === 1'b1) begin
                t.rh = i2c_rh_wl; t.addr = i2c_addr; t.data = i2c_data_w; t.cyc = cyc;
                log_q.push_back(t);
                if (t.rh) rd_cnt++;
                drop = (fault_kind == K_DROP_WR && !t.rh && t.addr == fault_addr) ||
                       (drop_rd && t.rh);
                if (drop) begin
                    step();
                end else begin
                    nack = (fault_kind == K_NACK_WR && !t.rh && t.addr == fault_addr) ||
                           (fault_kind == K_NACK_RD &&  t.rh && t.addr == fault_addr);
                    if (!t.rh) mem[t.addr[7:0]] = t.data;
                    rd = (fault_kind == K_BAD_RD && t.rh && t.addr == fault_addr) ?
                         8'hFF : mem[t.addr[7:0]];
                    for (int k = 0; k < slv_lat; k++) begin
                        step();
                        if (i2c_rh_wl !== t.rh || i2c_addr !== t.addr || i2c_data_w !== t.data)
                            hold_err++;
                    end
                    slv_done = 1'b1; slv_ack = nack; slv_rdata = rd;
                    done_set_cyc = cyc;
                    done_cnt++;
                    step();
                    slv_done = 1'b0; slv_ack = 1'b0; slv_rdata = 8'($urandom);
                end
            end else begin
                step();
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        chk("rst_ctl", {28'h0, i2c_exec, i2c_rh_wl, rw_done, rw_result}, 32'h0);
        chk("rst_addr_data", {8'h0, i2c_addr, i2c_data_w}, 32'h0);
        chk("rst_fail_addr", {16'h0, fail_addr}, 32'h0);
        step();
        rst_n = 1'b1;
        rel_cyc = cyc;
        log_q.delete();
    endtask

    task automatic start_scn(input int kind, input logic [15:0] faddr, input int lat);
        fault_kind = kind;
        fault_addr = faddr;
        slv_lat    = lat;
        hold_err   = 0;
        rd_cnt     = 0;
        build_model(kind, faddr);
        do_reset();
    endtask

    task automatic wait_done(output int seen);
        for (int k = 0; k < 3000 && rw_done !== 1'b1; k++) step();
        seen = cyc;
    endtask

    task automatic finish_scn(input int kind);
        int   seen, n0, lat;
        logic r0;
        wait_done(seen);
        chk("rw_done", {31'h0, rw_done}, 32'h1);
        chk("rw_result", {31'h0, rw_result}, {31'h0, exp_res});
        chk("fail_addr", {16'h0, fail_addr}, {16'h0, exp_fa});
        if (kind == K_DROP_WR) begin
            lat = (log_q.size() > 0) ? seen - log_q[log_q.size()-1].cyc : -1;
            chk("timeout_latency", {31'h0, (lat >= P_TIMEOUT && lat <= P_TIMEOUT + 1)}, 32'h1);
        end else begin
            chk("done_latency", seen - done_set_cyc, 32'd1);
        end
        n0 = log_q.size();
        r0 = rw_result;
        repeat (30) step();
        chk("no_exec_after_done", log_q.size(), n0);
        chk("result_sticky", {30'h0, rw_done, rw_result}, {30'h0, 1'b1, r0});
        chk("txn_count", log_q.size(), exp_q.size());
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            chk($sformatf("txn%0d", i), {7'h0, log_q[i].rh, log_q[i].addr, log_q[i].data},
                {7'h0, exp_q[i].rh, exp_q[i].addr, exp_q[i].data});
        chk("field_hold", hold_err, 32'd0);
    endtask

    initial begin : main
        int base, kind, idx;

        // Ideal slave: full pass, start delay, write spacing.
        start_scn(K_NONE, 16'h0, 20);
        finish_scn(K_NONE);
        if (log_q.size() > 0) chk("start_dly", log_q[0].cyc - rel_cyc, P_START_DLY);
        for (int i = 1; i < P_WR_BYTES && i < log_q.size(); i++)
            chk($sformatf("wr_spacing%0d", i),
                {31'h0, (log_q[i].cyc - log_q[i-1].cyc) >= (20 + P_WAIT + 1)}, 32'h1);

        // NACK on second write.
        start_scn(K_NACK_WR, 16'h0011, $urandom_range(2, 25));
        finish_scn(K_NACK_WR);

        // Bad readback at 0x12.
        start_scn(K_BAD_RD, 16'h0012, $urandom_range(2, 25));
        finish_scn(K_BAD_RD);

        // No done for the first write: timeout.
        start_scn(K_DROP_WR, 16'h0010, 20);
        finish_scn(K_DROP_WR);

        // Reset during RD_WAIT, then a late done while idling.
        drop_rd = 1'b1;
        start_scn(K_NONE, 16'h0, $urandom_range(2, 25));
        for (int k = 0; k < 2000 && rd_cnt == 0; k++) step();
        chk("rd_wait_reached", {31'h0, rd_cnt > 0}, 32'h1);
        repeat (3) step();
        do_reset();
        drop_rd = 1'b0;
        step();
        tb_done = 1'b1; tb_ack = 1'($urandom_range(0, 1));
        step();
        tb_done = 1'b0; tb_ack = 1'b0;
        finish_scn(K_NONE);
        if (log_q.size() > 0) chk("restart_dly", log_q[0].cyc - rel_cyc, P_START_DLY);

        // Spurious done in IDLE and in WR_GAP.
        start_scn(K_NONE, 16'h0, $urandom_range(2, 25));
        repeat ($urandom_range(0, 2)) step();
        tb_done = 1'b1; tb_ack = 1'($urandom_range(0, 1));
        step();
        tb_done = 1'b0; tb_ack = 1'b0;
        base = done_cnt;
        for (int k = 0; k < 2000 && done_cnt == base; k++) step();
        repeat (3) step();
        tb_done = 1'b1;
        step();
        tb_done = 1'b0;
        finish_scn(K_NONE);
        if (log_q.size() > 0) chk("spur_start_dly", log_q[0].cyc - rel_cyc, P_START_DLY);

        // Randomized fault kind, position and slave latency.
        for (int s = 0; s < 4; s++) begin
            kind = $urandom_range(0, 4);
            idx  = $urandom_range(0, P_WR_BYTES - 1);
            start_scn(kind, P_ADDR + 16'(idx), $urandom_range(2, 30));
            finish_scn(kind);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
